// File: rtl/tdm_demux.sv
// tdm_demux: receive end of a round-robin TDM channel mux.
//   A single serial sample stream carries N_CH interleaved channels. Each
//   accepted sample is steered into its channel holding register with a
//   one-cycle per-channel strobe. Framing is recovered from a frame_sync
//   marker on channel 0, and the block realigns whenever that marker arrives
//   early or is missing.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous reset, active-high
//   din        in   W        serial sample
//   din_valid  in   1        din carries a sample this cycle
//   frame_sync in   1        marks din as channel 0 (only with din_valid)
//   ch_data    out  N_CH*W   channel registers, channel k at [k*W +: W]
//   ch_valid   out  N_CH     bit k pulses when channel k is written
//   frame_done out  1        pulses when the last channel of a frame is stored
//   locked     out  1        high while frame alignment is held
//   sync_err   out  1        pulses on an early or missing frame_sync
module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 8,
  parameter int CW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [N_CH*W-1:0] ch_data,
  output logic [N_CH-1:0]   ch_valid,
  output logic              frame_done,
  output logic              locked,
  output logic              sync_err
);

  typedef enum logic {HUNT, LOCK} state_t;

  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);
  localparam logic [CW-1:0] FIRST_CH_NEXT = CW'(1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          wr;
  logic [CW-1:0] wr_idx;
  logic          done_nx;
  logic          err_nx;

  // Next-state decode. Idle cycles leave state and counter untouched and
  // produce no write, so every pulse naturally falls back to 0.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wr       = 1'b0;
    wr_idx   = '0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (frame_sync) begin
            wr       = 1'b1;
            cnt_nx   = FIRST_CH_NEXT;
            state_nx = LOCK;
          end
        end
        LOCK: begin
          if (frame_sync) begin
            // A marker mid-frame abandons the partial frame and restarts
            // at channel 0 without dropping lock.
            wr     = 1'b1;
            cnt_nx = FIRST_CH_NEXT;
            err_nx = (cnt != '0);
          end else if (cnt == '0) begin
            // Expected a marker here: the frame slipped, go back to hunting.
            err_nx   = 1'b1;
            state_nx = HUNT;
          end else begin
            wr     = 1'b1;
            wr_idx = cnt;
            if (cnt == LAST_CH) begin
              done_nx = 1'b1;
              cnt_nx  = '0;
            end else begin
              cnt_nx = cnt + FIRST_CH_NEXT;
            end
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  // Register stage: control, channel data and strobes all update on the
  // edge that accepts the sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      cnt        <= '0;
      ch_data    <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      frame_done <= done_nx;
      sync_err   <= err_nx;
      for (int k = 0; k < N_CH; k++) begin
        ch_valid[k] <= wr && (wr_idx == CW'(k));
        if (wr && (wr_idx == CW'(k))) begin
          ch_data[k*W +: W] <= din;
        end
      end
    end
  end

  assign locked = (state == LOCK);

endmodule
